uart_tx_scheduler: RTL and testbench
====================================

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 Parameter MAX_BURST, default 16: maximum bytes one requester may send per grant before forced release; legal range 1..255.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 req0_valid  input  1  requester 0 presents a byte.
REQ-005 req0_data  input  8  requester 0 byte.
REQ-006 req0_last  input  1  requester 0 byte ends its message.
REQ-007 req0_ready  output  1  requester 0 byte accepted this cycle when req0_valid is also 1.
REQ-008 req1_valid, req1_data[7:0], req1_last, req1_ready SHALL have the same directions, widths and meanings for requester 1.
REQ-009 tx_full  input  1  uart_tx buffer_full.
REQ-010 tx_data  output  8  byte to uart_tx data_in.
REQ-011 tx_write  output  1  one-cycle pulse to uart_tx write_buffer.
REQ-012 grant  output  2  one-hot current owner: bit0 = req0, bit1 = req1, 00 = none.
REQ-013 busy  output  1  1 whenever grant is not 00.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, OWN0 and OWN1; grant SHALL be 01 in OWN0, 10 in OWN1 and 00 in IDLE.
REQ-015 In IDLE with exactly one reqN_valid=1, the FSM SHALL move to OWNN on the next edge.
REQ-016 In IDLE with both valid, the FSM SHALL grant the requester that was not served last (round-robin pointer last_served).
REQ-017 In IDLE, reqN_ready SHALL be 0; the grant decision costs exactly one cycle.
REQ-018 In OWNN, reqN_ready SHALL be combinationally 1 iff tx_full=0 and tx_write=0; the other requester's ready SHALL be 0.
REQ-019 A transfer occurs when reqN_valid and reqN_ready are both 1; on the next edge tx_data SHALL load reqN_data and tx_write SHALL be 1 for exactly one cycle.
REQ-020 Consequences: at most one byte per two cycles; tx_write SHALL never be asserted in two consecutive cycles; no byte SHALL be written while tx_full=1 at the accept cycle.
REQ-021 tx_data SHALL hold its last value when tx_write=0.
REQ-022 The burst counter SHALL clear on entry to OWNN and increment by 1 per transfer; its width SHALL be sufficient for MAX_BURST with no wrap.
REQ-023 A transfer with reqN_last=1 SHALL move the FSM to IDLE on the same edge that raises tx_write, and SHALL set last_served=N.
REQ-024 A transfer that brings the burst counter to MAX_BURST SHALL release the grant in the same way even when reqN_last=0.
REQ-025 While in OWNN, a deasserted reqN_valid SHALL NOT release the grant; the owner keeps the grant until its last byte or until MAX_BURST.
REQ-026 A tx_full=1 level SHALL stall the owner indefinitely with no loss or duplication of bytes.
REQ-027 A new request arriving while another requester owns the grant SHALL wait; after release it SHALL be granted on the next IDLE evaluation.

Reset
REQ-028 While reset=0, asynchronously: FSM=IDLE, grant=00, busy=0, tx_write=0, tx_data=8'h00, req0_ready=0, req1_ready=0, burst counter=0, last_served=1 (req0 wins the first tie).
REQ-029 Reset asserted mid-message SHALL abandon the message; the byte pending in the tx_write register SHALL NOT be written.
REQ-030 After reset release, the first grant decision SHALL occur on the first rising edge with reset=1.

Verification
REQ-031 Single request: req0 sends "HI" (8'h48, then 8'h49 with last=1), tx_full=0 -> grant=01 one cycle after valid; tx_write pulses carrying 48 then 49, two cycles apart; grant=00 after the 49 write.
REQ-032 Tie: both valid from reset -> req0 served first; then req1; then req0 again if both remain valid (strict alternation).
REQ-033 Backpressure: tx_full=1 for 50 cycles during a req1 message -> req1_ready=0 and no tx_write during the stall; the stream resumes intact with no duplicate byte.
REQ-034 Forced release: MAX_BURST=4, req0 streams 10 bytes with last=0 and req1 is waiting -> after 4 writes grant passes to req1; req0 resumes from its fifth byte afterward.
REQ-035 Reset mid-message: reset=0 in the cycle after a transfer -> no tx_write pulse; all outputs at their reset values immediately.
REQ-036 Protocol checker for the whole run: grant is one-hot or zero; tx_write is never high in two consecutive cycles; no write follows an accept cycle that had tx_full=1.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// Two-requester round-robin byte scheduler feeding a single uart_tx buffer.
// The owner keeps the grant until its last byte or MAX_BURST bytes, whichever comes first.
module uart_tx_scheduler #(
  parameter int MAX_BURST = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic       req1_last,
  output logic       req1_ready,
  input  logic       tx_full,
  output logic [7:0] tx_data,
  output logic       tx_write,
  output logic [1:0] grant,
  output logic       busy,
  output logic [1:0] state_dbg
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic          last_served, last_served_nxt;
  logic [CW-1:0] burst_cnt, burst_nxt, burst_inc;
  logic          xfer0, xfer1, xfer;
  logic [7:0]    xfer_data;

  // Handshake: a byte moves when reqN_valid && reqN_ready are both 1 at a rising
  // edge; ready is only offered to the owner, and never while the buffer is full
  // or while the previous byte's tx_write pulse is still out.
  always_comb begin
    state_nxt       = state;
    last_served_nxt = last_served;
    req0_ready      = 1'b0;
    req1_ready      = 1'b0;
    grant           = 2'b00;
    xfer0           = 1'b0;
    xfer1           = 1'b0;
    burst_inc       = burst_cnt + CW'(1);
    case (state)
      IDLE: begin
        if (req0_valid && (!req1_valid || last_served)) state_nxt = OWN0;
        else if (req1_valid)                             state_nxt = OWN1;
      end
      OWN0: begin
        grant      = 2'b01;
        req0_ready = !tx_full && !tx_write;
        xfer0      = req0_valid && !tx_full && !tx_write;
        if (xfer0 && (req0_last || burst_inc == MAX_CNT)) begin
          state_nxt       = IDLE;
          last_served_nxt = 1'b0;
        end
      end
      OWN1: begin
        grant      = 2'b10;
        req1_ready = !tx_full && !tx_write;
        xfer1      = req1_valid && !tx_full && !tx_write;
        if (xfer1 && (req1_last || burst_inc == MAX_CNT)) begin
          state_nxt       = IDLE;
          last_served_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign xfer      = xfer0 || xfer1;
  assign xfer_data = xfer1 ? req1_data : req0_data;
  assign busy      = |grant;
  assign state_dbg = state;

  // The counter is held at zero in IDLE so every new ownership starts a fresh burst.
  always_comb begin
    burst_nxt = burst_cnt;
    if (state == IDLE) burst_nxt = '0;
    else if (xfer)     burst_nxt = burst_inc;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      last_served <= 1'b1;
      burst_cnt   <= '0;
      tx_data     <= 8'h00;
      tx_write    <= 1'b0;
    end else begin
      state       <= state_nxt;
      last_served <= last_served_nxt;
      burst_cnt   <= burst_nxt;
      tx_write    <= xfer;
      if (xfer) tx_data <= xfer_data;
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: cycle table for single/contended grants, then
// queued-stream sequences for tie alternation, backpressure, forced release and reset.
module tb_uart_tx_scheduler;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       req0_valid = 1'b0, req0_last = 1'b0, req1_valid = 1'b0, req1_last = 1'b0;
  logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
  logic       tx_full = 1'b0;
  logic       req0_ready, req1_ready, tx_write, busy;
  logic [7:0] tx_data;
  logic [1:0] grant, state_dbg;

  int test_cnt = 0;
  int fail_cnt = 0;

  uart_tx_scheduler #(.MAX_BURST(4)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
    .tx_full(tx_full), .tx_data(tx_data), .tx_write(tx_write),
    .grant(grant), .busy(busy), .state_dbg(state_dbg)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    test_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Protocol checker, sampled mid-cycle.
  logic prev_wr = 1'b0, prev_hs_full = 1'b0;
  always @(negedge clock) begin
    if (!reset) begin
      prev_wr      = 1'b0;
      prev_hs_full = 1'b0;
    end else begin
      check("grant_onehot", grant != 2'b11, 1);
      check("busy_vs_grant", busy, grant != 2'b00);
      if (prev_wr)      check("tx_write_consecutive", tx_write, 0);
      if (prev_hs_full) check("write_after_full_accept", tx_write, 0);
      check("accept_while_full", ((req0_valid && req0_ready) || (req1_valid && req1_ready)) && tx_full, 0);
      prev_wr      = tx_write;
      prev_hs_full = ((req0_valid && req0_ready) || (req1_valid && req1_ready)) && tx_full;
    end
  end

  // Stream driver and scoreboard: src queues hold {last, data}.
  logic [8:0] src0_q[$];
  logic [8:0] src1_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic       acc0, acc1;

  task automatic drive();
    req0_valid = src0_q.size() > 0;
    {req0_last, req0_data} = (src0_q.size() > 0) ? src0_q[0] : 9'h000;
    req1_valid = src1_q.size() > 0;
    {req1_last, req1_data} = (src1_q.size() > 0) ? src1_q[0] : 9'h000;
  endtask

  task automatic step();
    @(negedge clock);
    acc0 = req0_valid && req0_ready;
    acc1 = req1_valid && req1_ready;
    if (tx_write) got_q.push_back(tx_data);
    @(posedge clock);
    #1;
    if (acc0 && src0_q.size() > 0) void'(src0_q.pop_front());
    if (acc1 && src1_q.size() > 0) void'(src1_q.pop_front());
    drive();
  endtask

  task automatic run_until(input int n, input int budget, input string name);
    int k = 0;
    while (got_q.size() < n && k < budget) begin
      step();
      k++;
    end
    check({name, "_within_budget"}, got_q.size() >= n, 1);
  endtask

  task automatic compare_q(input string name);
    check({name, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_byte%0d", name, i), got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_grant"}, grant, 2'b00);
    check({name, "_busy"}, busy, 0);
    check({name, "_tx_write"}, tx_write, 0);
    check({name, "_tx_data"}, tx_data, 8'h00);
    check({name, "_req0_ready"}, req0_ready, 0);
    check({name, "_req1_ready"}, req1_ready, 0);
    check({name, "_state"}, state_dbg, 2'd0);
  endtask

  task automatic do_reset();
    reset   = 1'b0;
    tx_full = 1'b0;
    src0_q.delete();
    src1_q.delete();
    drive();
    #1;
    check_reset_outputs("reset");
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    got_q.delete();
    exp_q.delete();
  endtask

  typedef struct {
    logic       v0;
    logic [7:0] d0;
    logic       l0;
    logic       v1;
    logic [7:0] d1;
    logic       l1;
    logic       full;
    logic [1:0] e_grant;
    logic       e_r0;
    logic       e_r1;
    logic       e_wr;
    logic [7:0] e_data;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int r_seen, w_seen;
    // "HI" from req0, then req1 blocked by tx_full while req0 waits, then req0.
    vecs[0]  = '{1'b1, 8'h48, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[1]  = '{1'b1, 8'h48, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[2]  = '{1'b1, 8'h49, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1, 8'h48};
    vecs[3]  = '{1'b1, 8'h49, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 8'h48};
    vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 8'h49};
    vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 8'h49};
    vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h5A, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 8'h49};
    vecs[7]  = '{1'b1, 8'h77, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 8'h49};
    vecs[8]  = '{1'b1, 8'h77, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 1'b0, 8'h49};
    vecs[9]  = '{1'b1, 8'h77, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 8'h5A};
    vecs[10] = '{1'b1, 8'h77, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 8'h5A};
    vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 8'h77};
    vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 8'h77};

    do_reset();
    for (int i = 0; i < 13; i++) begin
      req0_valid = vecs[i].v0; req0_data = vecs[i].d0; req0_last = vecs[i].l0;
      req1_valid = vecs[i].v1; req1_data = vecs[i].d1; req1_last = vecs[i].l1;
      tx_full    = vecs[i].full;
      @(negedge clock);
      check($sformatf("vec%0d_grant", i), grant, vecs[i].e_grant);
      check($sformatf("vec%0d_busy", i), busy, vecs[i].e_grant != 2'b00);
      check($sformatf("vec%0d_req0_ready", i), req0_ready, vecs[i].e_r0);
      check($sformatf("vec%0d_req1_ready", i), req1_ready, vecs[i].e_r1);
      check($sformatf("vec%0d_tx_write", i), tx_write, vecs[i].e_wr);
      check($sformatf("vec%0d_tx_data", i), tx_data, vecs[i].e_data);
      @(posedge clock);
      #1;
    end

    // Tie from reset: req0 first, then strict alternation.
    do_reset();
    src0_q = '{9'h1A0, 9'h1A1};
    src1_q = '{9'h1B0, 9'h1B1};
    drive();
    @(posedge clock);
    #1;
    check("tie_first_grant", grant, 2'b01);
    run_until(4, 40, "tie");
    exp_q = '{8'hA0, 8'hB0, 8'hA1, 8'hB1};
    compare_q("tie_order");

    // Backpressure: 50-cycle tx_full stall inside a req1 message.
    do_reset();
    src1_q = '{9'h0C0, 9'h0C1, 9'h1C2};
    drive();
    run_until(1, 20, "bp_first");
    tx_full = 1'b1;
    r_seen = 0;
    w_seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (req1_ready) r_seen++;
      if (tx_write)   w_seen++;
      @(posedge clock);
      #1;
    end
    check("bp_ready_during_stall", r_seen, 0);
    check("bp_write_during_stall", w_seen, 0);
    check("bp_grant_held", grant, 2'b10);
    tx_full = 1'b0;
    run_until(3, 30, "bp_resume");
    exp_q = '{8'hC0, 8'hC1, 8'hC2};
    compare_q("bp_stream");
    step();
    step();
    check("bp_release_grant", grant, 2'b00);

    // Forced release after 4 bytes with req1 waiting; req0 resumes at its fifth byte.
    do_reset();
    for (int i = 0; i < 10; i++) src0_q.push_back({(i == 9) ? 1'b1 : 1'b0, 8'h10 + 8'(i)});
    src1_q = '{9'h020, 9'h121};
    drive();
    run_until(12, 100, "burst");
    exp_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h21,
              8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h19};
    compare_q("burst_order");

    // Reset in the cycle right after a transfer: pending write is dropped.
    do_reset();
    src0_q = '{9'h055, 9'h156};
    drive();
    acc0 = 1'b0;
    for (int k = 0; k < 10 && !acc0; k++) step();
    check("mid_accept_seen", acc0, 1);
    check("mid_write_pending", tx_write, 1);
    reset = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    @(negedge clock);
    check("mid_no_write", tx_write, 0);
    check("mid_no_capture", got_q.size(), 0);
    do_reset();

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

  initial begin
    #500000;
    fail_cnt++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $fatal(1, "watchdog expired");
  end

endmodule
